// File: rtl/cmvn_norm_if.sv
// Frame-stream, coefficient-write and status signals of the CMVN stage.
// The master side feeds features and coefficients; the slave side is the normaliser.
interface cmvn_norm_if;
    logic        cmvn_en;
    logic        feat_valid;
    logic [31:0] feat_data;
    logic [4:0]  feat_addr;
    logic        coef_we;
    logic        coef_sel;
    logic [4:0]  coef_addr;
    logic [31:0] coef_data;
    logic [31:0] cmvn_output_data;
    logic [4:0]  cmvn_output_addr;
    logic        cmvn_output_valid;
    logic        frame_done;
    logic        busy;
    logic        addr_err;

    modport master (
        output cmvn_en, feat_valid, feat_data, feat_addr,
        output coef_we, coef_sel, coef_addr, coef_data,
        input  cmvn_output_data, cmvn_output_addr, cmvn_output_valid,
        input  frame_done, busy, addr_err
    );

    modport slave (
        input  cmvn_en, feat_valid, feat_data, feat_addr,
        input  coef_we, coef_sel, coef_addr, coef_data,
        output cmvn_output_data, cmvn_output_addr, cmvn_output_valid,
        output frame_done, busy, addr_err
    );
endinterface

// File: rtl/cmvn_norm.sv
// Per-frame CMVN: y[i] = sat((x[i] - mean[i]) * istd[i] >>> FRAC), two-stage pipeline.
// state | meaning
// IDLE  | waiting for cmvn_en; coefficient writes allowed
// RUN   | accepting features in index order
// DRAIN | last feature accepted, waiting for the pipeline to empty
// DONE  | frame_done pulse, back to IDLE
module cmvn_norm #(
    parameter int NUM_FEAT = 20,
    parameter int FRAC     = 24
) (
    input  logic        clk,
    input  logic        rst,
    cmvn_norm_if.slave  io_bus
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    localparam logic [4:0]         LAST_ADDR = 5'(NUM_FEAT - 1);
    localparam logic signed [64:0] SAT_MAX   = {33'h0, 32'h7FFF_FFFF};
    localparam logic signed [64:0] SAT_MIN   = {{33{1'b1}}, 32'h8000_0000};

    state_t             r_state;
    logic [4:0]         r_counter;
    logic               r_busy;
    logic               r_frame_done;
    logic               r_addr_err;

    logic [31:0]        r_mean [NUM_FEAT];
    logic [31:0]        r_istd [NUM_FEAT];

    logic               r_s1_valid;
    logic signed [32:0] r_s1_diff;
    logic signed [31:0] r_s1_istd;
    logic [4:0]         r_s1_addr;

    logic               r_out_valid;
    logic [31:0]        r_out_data;
    logic [4:0]         r_out_addr;

    logic               w_accept;
    logic               w_coef_wr;
    logic signed [64:0] w_prod;
    logic signed [64:0] w_res;
    logic [31:0]        w_sat;

    assign w_accept  = (r_state == ST_RUN) && io_bus.feat_valid
                       && (io_bus.feat_addr == r_counter);
    assign w_coef_wr = io_bus.coef_we && !r_busy
                       && ({1'b0, io_bus.coef_addr} < 6'(NUM_FEAT));

    // Coefficient file keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (w_coef_wr) begin
            if (io_bus.coef_sel)
                r_istd[io_bus.coef_addr] <= io_bus.coef_data;
            else
                r_mean[io_bus.coef_addr] <= io_bus.coef_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_counter    <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_addr_err   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (io_bus.cmvn_en) begin
                        r_state    <= ST_RUN;
                        r_counter  <= '0;
                        r_addr_err <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (io_bus.feat_valid) begin
                        if (io_bus.feat_addr == r_counter) begin
                            r_counter <= r_counter + 5'd1;
                            if (r_counter == LAST_ADDR)
                                r_state <= ST_DRAIN;
                        end else begin
                            r_addr_err <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Once S1 is empty the final result sits in the output register this
                    // cycle, so the pulse lands exactly one cycle after the last output.
                    if (!r_s1_valid) begin
                        r_state      <= ST_DONE;
                        r_frame_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_prod = r_s1_diff * r_s1_istd;
    assign w_res  = w_prod >>> FRAC;

    always_comb begin
        w_sat = w_res[31:0];
        if (w_res > SAT_MAX)
            w_sat = 32'h7FFF_FFFF;
        else if (w_res < SAT_MIN)
            w_sat = 32'h8000_0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_diff   <= '0;
            r_s1_istd   <= '0;
            r_s1_addr   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_diff <= $signed({io_bus.feat_data[31], io_bus.feat_data})
                           - $signed({r_mean[r_counter][31], r_mean[r_counter]});
                r_s1_istd <= r_istd[r_counter];
                r_s1_addr <= r_counter;
            end
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_sat;
                r_out_addr <= r_s1_addr;
            end
        end
    end

    assign io_bus.cmvn_output_data  = r_out_data;
    assign io_bus.cmvn_output_addr  = r_out_addr;
    assign io_bus.cmvn_output_valid = r_out_valid;
    assign io_bus.frame_done        = r_frame_done;
    assign io_bus.busy              = r_busy;
    assign io_bus.addr_err          = r_addr_err;

endmodule

// File: tb/tb_cmvn_norm.sv
// Scoreboard bench for cmvn_norm: stimulus pushes expected outputs, a negedge monitor checks them.
module tb_cmvn_norm;
    localparam int NF = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cmvn_norm_if bus ();

    cmvn_norm #(.NUM_FEAT(NF), .FRAC(24)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus.slave)
    );

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        int          c;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          out_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = -10;
    int          last_out_cyc = -10;
    int          last_out_addr = -1;
    logic [31:0] m_mean [32];
    logic [31:0] m_istd [32];
    logic [31:0] fx [32];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: exact rational product, floor division by 2^24, then clamp to 32 bits.
    function automatic logic [31:0] ref_y(logic [31:0] x, logic [31:0] m, logic [31:0] s);
        logic signed [127:0] xs, ms, ss, p, qt;
        xs = {{96{x[31]}}, x};
        ms = {{96{m[31]}}, m};
        ss = {{96{s[31]}}, s};
        p  = (xs - ms) * ss;
        qt = p / 128'sd16777216;
        if (p < 0 && (p % 128'sd16777216) != 0)
            qt = qt - 1;
        if (qt > 128'sd2147483647)
            return 32'h7FFF_FFFF;
        if (qt < -128'sd2147483648)
            return 32'h8000_0000;
        return qt[31:0];
    endfunction

    always @(negedge clk) begin
        if (bus.cmvn_output_valid === 1'b1) begin
            out_cnt++;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_output: got addr %0d data %0h want no output (cycle %0d)",
                         bus.cmvn_output_addr, bus.cmvn_output_data, cyc);
            end else begin
                mon_e = q.pop_front();
                check("out_data", bus.cmvn_output_data, mon_e.d);
                check("out_addr", bus.cmvn_output_addr, mon_e.a);
                check("out_latency_cycle", cyc, mon_e.c);
            end
            last_out_cyc  = cyc;
            last_out_addr = int'(bus.cmvn_output_addr);
        end
        if (bus.frame_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input logic sel, input logic [4:0] a, input logic [31:0] d);
        bus.coef_we   = 1'b1;
        bus.coef_sel  = sel;
        bus.coef_addr = a;
        bus.coef_data = d;
        tick();
        bus.coef_we = 1'b0;
        if (int'(a) < NF) begin
            if (sel) m_istd[a] = d;
            else     m_mean[a] = d;
        end
    endtask

    task automatic start_frame();
        bus.cmvn_en = 1'b1;
        tick();
        bus.cmvn_en = 1'b0;
        check("busy_after_start", bus.busy, 1);
    endtask

    task automatic send(input int a, input logic [31:0] d, input bit accept);
        exp_t e;
        bus.feat_valid = 1'b1;
        bus.feat_addr  = 5'(a);
        bus.feat_data  = d;
        if (accept) begin
            e.a = 5'(a);
            e.d = ref_y(d, m_mean[a], m_istd[a]);
            e.c = cyc + 2;
            q.push_back(e);
        end
        tick();
        bus.feat_valid = 1'b0;
    endtask

    task automatic finish_frame(input bit exp_err);
        int start_cnt;
        int k;
        start_cnt = done_cnt;
        bus.feat_valid = 1'b0;
        k = 0;
        while (done_cnt == start_cnt && k < 80) begin
            tick();
            k++;
        end
        check("frame_done_count", done_cnt, start_cnt + 1);
        check("frame_done_after_last_out", done_cyc, last_out_cyc + 1);
        check("last_out_addr", last_out_addr, NF - 1);
        check("queue_empty_at_done", q.size(), 0);
        check("busy_low_after_done", bus.busy, 0);
        check("addr_err_at_end", bus.addr_err, exp_err);
    endtask

    task automatic full_frame(input int gap_pct);
        start_frame();
        for (int i = 0; i < NF; i++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                bus.feat_addr = 5'($urandom_range(31));
                bus.feat_data = $urandom;
                tick();
            end
            send(i, fx[i], 1'b1);
        end
        finish_frame(1'b0);
    endtask

    task automatic rand_fx();
        for (int i = 0; i < NF; i++) fx[i] = $urandom;
    endtask

    int oc, dc;

    initial begin
        bus.cmvn_en    = 1'b0;
        bus.feat_valid = 1'b0;
        bus.feat_data  = '0;
        bus.feat_addr  = '0;
        bus.coef_we    = 1'b0;
        bus.coef_sel   = 1'b0;
        bus.coef_addr  = '0;
        bus.coef_data  = '0;
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_valid", bus.cmvn_output_valid, 0);
        check("rst_data", bus.cmvn_output_data, 0);
        check("rst_addr", bus.cmvn_output_addr, 0);
        check("rst_frame_done", bus.frame_done, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_addr_err", bus.addr_err, 0);
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < NF; i++) begin
            write_coef(1'b0, 5'(i), $urandom);
            write_coef(1'b1, 5'(i), 32'($urandom_range(32'h0200_0000)));
        end

        // Basic single-value case plus random remainder
        write_coef(1'b0, 5'd0, 32'h0100_0000);
        write_coef(1'b1, 5'd0, 32'h0080_0000);
        rand_fx();
        fx[0] = 32'h0300_0000;
        full_frame(0);

        // Identity: mean 0, istd 1.0, back-to-back
        for (int i = 0; i < NF; i++) begin
            write_coef(1'b0, 5'(i), 32'h0);
            write_coef(1'b1, 5'(i), 32'h0100_0000);
        end
        rand_fx();
        full_frame(0);

        // Saturation both directions
        write_coef(1'b0, 5'd0, 32'h8000_0000);
        write_coef(1'b1, 5'd0, 32'h0200_0000);
        write_coef(1'b0, 5'd1, 32'h7FFF_FFFF);
        write_coef(1'b1, 5'd1, 32'h0200_0000);
        rand_fx();
        fx[0] = 32'h7FFF_FFFF;
        fx[1] = 32'h8000_0000;
        full_frame(0);

        // Out-of-order feature is dropped and flagged
        rand_fx();
        start_frame();
        for (int i = 0; i < 3; i++) send(i, fx[i], 1'b1);
        check("addr_err_before", bus.addr_err, 0);
        send(5, $urandom, 1'b0);
        check("addr_err_set", bus.addr_err, 1);
        for (int i = 3; i < NF; i++) send(i, fx[i], 1'b1);
        finish_frame(1'b1);

        // Writes and frame starts during busy are ignored; addr_err clears on start
        rand_fx();
        start_frame();
        check("addr_err_cleared", bus.addr_err, 0);
        for (int i = 0; i < 5; i++) send(i, fx[i], 1'b1);
        bus.coef_we   = 1'b1;
        bus.coef_sel  = 1'b0;
        bus.coef_addr = 5'd3;
        bus.coef_data = 32'h0ABC_DEF0;
        bus.cmvn_en   = 1'b1;
        tick();
        bus.coef_we = 1'b0;
        bus.cmvn_en = 1'b0;
        for (int i = 5; i < NF; i++) send(i, fx[i], 1'b1);
        finish_frame(1'b0);
        rand_fx();
        full_frame(20);

        // Coefficient write in the same cycle as the frame start takes effect
        write_coef(1'b0, 5'd25, 32'h1234_5678);
        bus.coef_we   = 1'b1;
        bus.coef_sel  = 1'b1;
        bus.coef_addr = 5'd2;
        bus.coef_data = 32'h0040_0000;
        m_istd[2]     = 32'h0040_0000;
        rand_fx();
        start_frame();
        bus.coef_we = 1'b0;
        for (int i = 0; i < NF; i++) send(i, fx[i], 1'b1);
        finish_frame(1'b0);

        // Random coefficients and gappy streams
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < NF; i++) begin
                write_coef(1'b0, 5'(i), $urandom);
                if ($urandom_range(3) == 0)
                    write_coef(1'b1, 5'(i), $urandom);
                else
                    write_coef(1'b1, 5'(i), 32'($urandom_range(32'h0400_0000)));
            end
            rand_fx();
            full_frame(30);
        end

        // Reset mid-frame flushes the pipeline
        rand_fx();
        start_frame();
        for (int i = 0; i < 10; i++) send(i, fx[i], 1'b1);
        rst = 1'b1;
        tick();
        q.delete();
        oc = out_cnt;
        dc = done_cnt;
        repeat (2) tick();
        rst = 1'b0;
        repeat (8) tick();
        check("rst_mid_no_outputs", out_cnt, oc);
        check("rst_mid_no_done", done_cnt, dc);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_data", bus.cmvn_output_data, 0);
        rand_fx();
        full_frame(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
